// File: rtl/i2c_slave_core_pkg.sv
// Shared I2C definitions: FSM state codes, byte constant and a small helper
// used by the slave core and its line conditioner.
package i2c_slave_core_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_ACK   = 3'd6,
        IGNORE   = 3'd7
    } state_t;

    localparam logic [7:0] ZERO8 = 8'h00;

    // 2-of-3 vote used by the optional glitch filter
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Line conditioner for one I2C pad signal: synchroniser into clk, optional
// 3-sample majority filter (I2C_SLAVE_GLITCH_FILTER_EN), and edge detection.
// All flops reset to 1 so the line looks like an idle, released bus.
module i2c_sync_edge
    import i2c_slave_core_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;
    logic                   clean;
    logic                   prev_reg;

    // Metastability chain, shifting toward the MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], line};
        end
    end

    assign synced = sync_reg[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist_reg;
    logic       filt_reg;

    // Vote over the current and two previous samples; a single-clk pulse
    // never holds a majority, so it is dropped (two extra clks of latency)
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_reg <= 2'b11;
            filt_reg <= 1'b1;
        end else begin
            hist_reg <= {hist_reg[0], synced};
            filt_reg <= maj3(synced, hist_reg[0], hist_reg[1]);
        end
    end

    assign clean = filt_reg;
`else
    assign clean = synced;
`endif

    // Previous conditioned level for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= clean;
        end
    end

    assign level = clean;
    assign rise  = clean & ~prev_reg;
    assign fall  = ~clean & prev_reg;

endmodule

// File: rtl/i2c_slave_core.sv
// I2C slave byte engine: address match, receive with ACK, transmit with
// master ACK/NACK handling. Never stretches scl. SDA is driven only on scl
// falling edges (plus immediate release on START/STOP/reset).
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN (majority filter on lines).
module i2c_slave_core
    import i2c_slave_core_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [6:0] address,
    input  logic [7:0] datasend,
    output logic [7:0] datareceive,
    output logic       received,
    output logic       sended,
    output logic       busy
);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .reset(reset), .line(scl),
        .level(scl_level), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .reset(reset), .line(sda_in),
        .level(sda_level), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_det = sda_fall & scl_level;
    assign stop_det  = sda_rise & scl_level;

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] tx_reg, tx_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       busy_reg, busy_next;
    logic [7:0] drx_reg, drx_next;
    logic       received_reg, received_next;
    logic       sended_reg, sended_next;
    logic [2:0] tx_idx;

    // Bit position to present after the n-th rising edge (MSB first)
    assign tx_idx = 3'd7 - bit_cnt_reg[2:0];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 4'd0;
            shift_reg    <= ZERO8;
            tx_reg       <= ZERO8;
            sda_oe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            drx_reg      <= ZERO8;
            received_reg <= 1'b0;
            sended_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            sda_oe_reg   <= sda_oe_next;
            busy_reg     <= busy_next;
            drx_reg      <= drx_next;
            received_reg <= received_next;
            sended_reg   <= sended_next;
        end
    end

    // Next-state logic; bus conditions take priority over bit handling
    always_comb begin
        state_next    = state_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        sda_oe_next   = sda_oe_reg;
        busy_next     = busy_reg;
        drx_next      = drx_reg;
        received_next = 1'b0;
        sended_next   = 1'b0;

        if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else if (stop_det) begin
            state_next   = IDLE;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                ADDR: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda_level};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        if (shift_reg[7:1] == address) begin
                            state_next  = ADDR_ACK;
                            sda_oe_next = 1'b1;
                            busy_next   = 1'b1;
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_next = 4'd0;
                        if (shift_reg[0]) begin
                            state_next  = TX;
                            tx_next     = datasend;
                            sda_oe_next = ~datasend[7];
                        end else begin
                            state_next  = RX;
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        shift_next   = {shift_reg[6:0], sda_level};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            drx_next      = {shift_reg[6:0], sda_level};
                            received_next = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        state_next  = RX_ACK;
                        sda_oe_next = 1'b1;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        state_next   = RX;
                        bit_cnt_next = 4'd0;
                        sda_oe_next  = 1'b0;
                    end
                end
                TX: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            state_next  = TX_ACK;
                            sda_oe_next = 1'b0;
                        end else begin
                            sda_oe_next = ~tx_reg[tx_idx];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        sended_next = 1'b1;
                        if (sda_level) begin
                            state_next = IGNORE;
                            busy_next  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        state_next   = TX;
                        bit_cnt_next = 4'd0;
                        tx_next      = datasend;
                        sda_oe_next  = ~datasend[7];
                    end
                end
                default: begin
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe      = sda_oe_reg;
    assign busy        = busy_reg;
    assign datareceive = drx_reg;
    assign received    = received_reg;
    assign sended      = sended_reg;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Bench for i2c_slave_core: a behavioural I2C master drives the bus, expected
// strobes are queued ahead of each byte and a monitor pops/compares them.
module tb_i2c_slave_core;

    localparam int Q = 8;   // clk cycles per quarter of an scl period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       msda = 1'b1;
    logic [6:0] address = 7'h3C;
    logic [7:0] datasend = 8'h00;
    logic       sda_oe;
    logic [7:0] datareceive;
    logic       received;
    logic       sended;
    logic       busy;
    logic       sda_line;

    assign sda_line = msda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_core #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda_in(sda_line),
        .sda_oe(sda_oe), .address(address), .datasend(datasend),
        .datareceive(datareceive), .received(received), .sended(sended),
        .busy(busy)
    );

    typedef struct packed {
        logic       is_tx;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_fail = 0;
    int  oe_viol = 0;
    logic watch_oe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_event(input logic is_tx, input logic [7:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_strobe: got %s data 0x%0h, expected none",
                     is_tx ? "sended" : "received", d);
        end else begin
            e = exp_q.pop_front();
            check("strobe_kind", {31'd0, is_tx}, {31'd0, e.is_tx});
            if (!is_tx) check("rx_data", {24'd0, d}, {24'd0, e.data});
        end
    endtask

    // Monitor: consume DUT strobes and track forbidden SDA drive
    always @(negedge clk) begin
        if (!reset) begin
            if (received) begin
                mon_event(1'b0, datareceive);
                $display("strobe received data=0x%02h", datareceive);
            end
            if (sended) begin
                mon_event(1'b1, 8'h00);
                $display("strobe sended");
            end
        end
        if (watch_oe && sda_oe) oe_viol++;
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic push_rx(input logic [7:0] d);
        ev_t e;
        e.is_tx = 1'b0;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic push_tx();
        ev_t e;
        e.is_tx = 1'b1;
        e.data  = 8'h00;
        exp_q.push_back(e);
    endtask

    // One scl period starting and ending with scl low; returns sampled SDA
    task automatic clock_bit(input logic b, input logic glitch, output logic s);
        wq();
        if (glitch) begin
            scl = 1'b1;
            @(negedge clk);
            scl = 1'b0;
        end
        msda = b;
        wq();
        scl = 1'b1;
        wq();
        s = sda_line;
        wq();
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        msda = 1'b1;
        wq();
        scl = 1'b1;
        wq();
        msda = 1'b0;
        wq();
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        msda = 1'b0;
        wq();
        scl = 1'b1;
        wq();
        msda = 1'b1;
        wq();
        wq();
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic s;
        for (int i = 0; i < 8; i++) clock_bit(b[7-i], (i == glitch_bit), s);
        clock_bit(1'b1, 1'b0, s);
        ack = ~s;
        $display("write 0x%02h ack=%0b", b, ack);
    endtask

    task automatic read_byte(input logic ack, input logic [7:0] ds_mid, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) datasend = ds_mid;
            clock_bit(1'b1, 1'b0, s);
            b = {b[6:0], s};
        end
        clock_bit(~ack, 1'b0, s);
        $display("read 0x%02h master_ack=%0b", b, ack);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rb;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_received", {31'd0, received}, 32'd0);
        check("rst_sended", {31'd0, sended}, 32'd0);
        check("rst_datareceive", {24'd0, datareceive}, 32'h00);
        reset = 1'b0;
        wq();

        // 1: write 0x78, 0xA5, STOP
        i2c_start();
        write_byte(8'h78, -1, ack);
        check("s1_addr_ack", {31'd0, ack}, 32'd1);
        check("s1_busy_after_addr", {31'd0, busy}, 32'd1);
        push_rx(8'hA5);
        write_byte(8'hA5, -1, ack);
        check("s1_data_ack", {31'd0, ack}, 32'd1);
        check("s1_busy_before_stop", {31'd0, busy}, 32'd1);
        i2c_stop();
        check("s1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("s1_hold_datareceive", {24'd0, datareceive}, 32'hA5);
        check("s1_queue_empty", exp_q.size(), 32'd0);

        // 2: address mismatch, slave must stay silent
        watch_oe = 1'b1;
        i2c_start();
        write_byte(8'h7A, -1, ack);
        check("s2_addr_nack", {31'd0, ack}, 32'd0);
        check("s2_busy", {31'd0, busy}, 32'd0);
        write_byte(8'h55, -1, ack);
        check("s2_data_nack", {31'd0, ack}, 32'd0);
        i2c_stop();
        watch_oe = 1'b0;
        check("s2_oe_never_driven", oe_viol, 32'd0);
        check("s2_queue_empty", exp_q.size(), 32'd0);

        // 3: read one byte 0x96 with NACK
        datasend = 8'h96;
        i2c_start();
        write_byte(8'h79, -1, ack);
        check("s3_addr_ack", {31'd0, ack}, 32'd1);
        push_tx();
        read_byte(1'b0, 8'h96, rb);
        check("s3_read_byte", {24'd0, rb}, 32'h96);
        check("s3_oe_released", {31'd0, sda_oe}, 32'd0);
        check("s3_busy_after_nack", {31'd0, busy}, 32'd0);
        i2c_stop();
        check("s3_queue_empty", exp_q.size(), 32'd0);

        // 4: write 0x01, repeated START, read 0x11 (ACK), 0x22 (NACK)
        i2c_start();
        write_byte(8'h78, -1, ack);
        check("s4_waddr_ack", {31'd0, ack}, 32'd1);
        push_rx(8'h01);
        write_byte(8'h01, -1, ack);
        check("s4_wdata_ack", {31'd0, ack}, 32'd1);
        datasend = 8'h11;
        i2c_start();
        write_byte(8'h79, -1, ack);
        check("s4_raddr_ack", {31'd0, ack}, 32'd1);
        push_tx();
        read_byte(1'b1, 8'h22, rb);
        check("s4_read_byte0", {24'd0, rb}, 32'h11);
        push_tx();
        read_byte(1'b0, 8'h22, rb);
        check("s4_read_byte1", {24'd0, rb}, 32'h22);
        i2c_stop();
        check("s4_busy_end", {31'd0, busy}, 32'd0);
        check("s4_queue_empty", exp_q.size(), 32'd0);

        // 5: reset after bit 4 of a read byte, then a clean write
        datasend = 8'h00;
        i2c_start();
        write_byte(8'h79, -1, ack);
        check("s5_addr_ack", {31'd0, ack}, 32'd1);
        for (int i = 0; i < 4; i++) clock_bit(1'b1, 1'b0, s);
        repeat (Q) @(negedge clk);
        check("s5_oe_before_reset", {31'd0, sda_oe}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("s5_oe_after_reset", {31'd0, sda_oe}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) clock_bit(1'b1, 1'b0, s);
        i2c_stop();
        check("s5_busy_after_reset", {31'd0, busy}, 32'd0);
        check("s5_queue_empty_no_sended", exp_q.size(), 32'd0);
        i2c_start();
        write_byte(8'h78, -1, ack);
        check("s5_retry_addr_ack", {31'd0, ack}, 32'd1);
        push_rx(8'h5A);
        write_byte(8'h5A, -1, ack);
        check("s5_retry_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("s5_retry_queue_empty", exp_q.size(), 32'd0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // 6: single-clk scl pulse inside a byte must not count as a bit
        i2c_start();
        write_byte(8'h78, -1, ack);
        check("s6_addr_ack", {31'd0, ack}, 32'd1);
        push_rx(8'hC3);
        write_byte(8'hC3, 3, ack);
        check("s6_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        check("s6_queue_empty", exp_q.size(), 32'd0);
`endif

        repeat (4 * Q) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_core.md
I2C_SLAVE_CORE -- requirements
Module: i2c_slave_core

Interface
- REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop stages synchronising scl/sda into clk (legal range 2..4).
- REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is posedge clk.
- REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-004 SHALL have port scl, input, 1 bit: I2C clock from the pad.
- REQ-005 SHALL have port sda_in, input, 1 bit: I2C data read from the pad.
- REQ-006 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases it.
- REQ-007 SHALL have port address, input, 7 bits: own slave address, supplied by the downstream driver.
- REQ-008 SHALL have port datasend, input, 8 bits: byte to transmit, from the driver.
- REQ-009 SHALL have port datareceive, output, 8 bits: last byte received after the address byte.
- REQ-010 SHALL have port received, output, 1 bit: one-clk strobe marking a new datareceive.
- REQ-011 SHALL have port sended, output, 1 bit: one-clk strobe marking completion of a transmitted byte.
- REQ-012 SHALL have port busy, output, 1 bit: 1 from an address match until STOP, START or NACK-end.

Function
- REQ-013 SHALL detect START as a synchronised sda 1->0 while scl=1, and STOP as sda 0->1 while scl=1.
- REQ-014 SHALL sample SDA on each synchronised scl rising edge and change sda_oe only on scl falling edges.
- REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
- REQ-016 SHALL, on START from any state including a repeated START mid-byte, clear the bit counter and go to ADDR with sda_oe=0.
- REQ-017 SHALL, on STOP from any state, go to IDLE with sda_oe=0 and busy=0.
- REQ-018 SHALL, after 8 bits in ADDR with bits[7:1]==address, drive sda_oe=1 for the 9th clock (ADDR_ACK) and set busy=1.
- REQ-019 SHALL enter RX after ADDR_ACK if R/W=0, or enter TX if R/W=1.
- REQ-020 SHALL, on address mismatch, leave sda_oe=0 and go to IGNORE until START or STOP.
- REQ-021 SHALL, in RX after 8 bits, update datareceive MSB-first, pulse received for exactly one clk on the 8th-bit rising edge, ACK in RX_ACK, then return to RX.
- REQ-022 SHALL hold datareceive stable between received strobes.
- REQ-023 SHALL capture datasend on the scl falling edge that enters TX, shift it MSB-first (sda_oe = ~bit), and release SDA in TX_ACK.
- REQ-024 SHALL, in TX_ACK, pulse sended for one clk on the 9th rising edge; master ACK (sda=0) -> TX with datasend reloaded; master NACK -> IGNORE with busy=0.
- REQ-025 SHALL never drive sda_oe=1 in IDLE or IGNORE, nor while the master drives an ACK bit.
- REQ-026 SHALL NOT stretch the clock (scl is input only).

Reset
- REQ-027 SHALL, while reset=1, set state=IDLE, sda_oe=0, datareceive=8'h00, received=0, sended=0, busy=0, bit counter=0, and synchroniser flops=1 (bus idle).
- REQ-028 SHALL, on reset mid-transfer, release SDA on the next clk and ignore bus activity until the next START.

Configuration
- REQ-029 SHALL, when macro I2C_SLAVE_GLITCH_FILTER_EN is defined, pass each synchronised line through a 3-sample majority filter (+2 clk latency, rejects 1-clk glitches); without it, use the raw synchroniser output.

Structure
- REQ-030 SHALL keep the state codes and ZERO8 constant in the shared I2C header alongside the driver's definitions.
- REQ-031 SHALL place synchroniser, optional filter and scl/sda edge detection in sub-module i2c_sync_edge, instantiated once per line.

Verification
- REQ-032 SHALL check: address=7'h3C, master writes 0x78, 0xA5, STOP -> ACK on both bytes, one received pulse with datareceive=8'hA5, busy 1->0 at STOP.
- REQ-033 SHALL check: master sends 0x7A (address mismatch) -> sda_oe stays 0 throughout, no strobes, IGNORE until STOP.
- REQ-034 SHALL check: address=7'h3C, datasend=8'h96, master sends 0x79 and reads one byte with NACK -> SDA carries 1001_0110, one sended pulse, sda_oe=0 afterwards.
- REQ-035 SHALL check: write 0x78, 0x01, repeated START, 0x79, read 2 bytes (ACK, NACK) with datasend 8'h11 then 8'h22 -> received once, sended twice, bytes 0x11, 0x22.
- REQ-036 SHALL check: reset asserted after bit 4 of a read byte -> sda_oe=0 the next clk, no sended; the next full transaction succeeds.
- REQ-037 SHALL check, with I2C_SLAVE_GLITCH_FILTER_EN defined: a 1-clk scl pulse mid-byte is rejected and does not shift the bit counter.
